// File: rtl/spi_reg_bank.sv
// Register bank fed by decoded SPI frames: a three-state accept/decode/commit
// pipeline writes five 8-bit config registers and keeps write/error counters.
module spi_reg_bank #(
  parameter int MAX_ADDR = 4,
  parameter int ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             txn_valid,
  input  logic             txn_rw,
  input  logic [6:0]       txn_addr,
  input  logic [7:0]       txn_data,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             cfg_update,
  output logic [7:0]       wr_count,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_HIT = 2'd0,
    CLS_RD  = 2'd1,
    CLS_BAD = 2'd2
  } cls_t;

  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

  state_t           state_r;
  state_t           state_s;
  cls_t             cls_r;
  cls_t             cls_s;
  logic             hold_rw_r;
  logic [6:0]       hold_addr_r;
  logic [7:0]       hold_data_r;
  logic             overrun_s;
  logic             commit_hit_s;
  logic             commit_err_s;
  logic [1:0]       err_inc_s;
  logic [7:0]       regs_r [5];
  logic             cfg_update_r;
  logic             busy_r;
  logic [7:0]       wr_count_r;
  logic [ERR_W-1:0] err_count_r;

  // Saturating add of a 0..2 increment; the carry bit flags overflow.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_W-1){1'b0}}, inc};
    if (sum[ERR_W]) begin
      return {ERR_W{1'b1}};
    end else begin
      return sum[ERR_W-1:0];
    end
  endfunction

  // Next-state, classification and commit/overrun strobes.
  always_comb begin
    state_s      = state_r;
    cls_s        = CLS_RD;
    overrun_s    = 1'b0;
    commit_hit_s = 1'b0;
    commit_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (txn_valid) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        state_s   = ST_COMMIT;
        overrun_s = txn_valid;
      end
      ST_COMMIT: begin
        state_s      = ST_IDLE;
        overrun_s    = txn_valid;
        commit_hit_s = (cls_r == CLS_HIT);
        commit_err_s = (cls_r != CLS_HIT);
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (!hold_rw_r) begin
      cls_s = CLS_RD;
    end else if (hold_addr_r <= MAX_ADDR_L) begin
      cls_s = CLS_HIT;
    end else begin
      cls_s = CLS_BAD;
    end
    err_inc_s = {1'b0, commit_err_s} + {1'b0, overrun_s};
  end

  // State, holding registers and registered classification.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cls_r       <= CLS_RD;
      hold_rw_r   <= 1'b0;
      hold_addr_r <= 7'd0;
      hold_data_r <= 8'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      if (state_r == ST_IDLE && txn_valid) begin
        hold_rw_r   <= txn_rw;
        hold_addr_r <= txn_addr;
        hold_data_r <= txn_data;
      end
      if (state_r == ST_DECODE) begin
        cls_r <= cls_s;
      end
    end
  end

  // Configuration registers, update pulse and debug counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        regs_r[i] <= 8'd0;
      end
      cfg_update_r <= 1'b0;
      wr_count_r   <= 8'd0;
      err_count_r  <= {ERR_W{1'b0}};
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (commit_hit_s && hold_addr_r == 7'(i)) begin
          regs_r[i] <= hold_data_r;
        end
      end
      cfg_update_r <= commit_hit_s;
      if (commit_hit_s) begin
        wr_count_r <= wr_count_r + 8'd1;
      end
      err_count_r <= sat_add(err_count_r, err_inc_s);
    end
  end

  assign en_reg_out_7_0  = regs_r[0];
  assign en_reg_out_15_8 = regs_r[1];
  assign en_reg_pwm_7_0  = regs_r[2];
  assign en_reg_pwm_15_8 = regs_r[3];
  assign pwm_duty_cycle  = regs_r[4];
  assign cfg_update      = cfg_update_r;
  assign wr_count        = wr_count_r;
  assign err_count       = err_count_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: a countdown-based transaction model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_spi_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       txn_valid;
  logic       txn_rw;
  logic [6:0] txn_addr;
  logic [7:0] txn_data;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       cfg_update;
  logic [7:0] wr_count;
  logic [3:0] err_count;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cfg_pulses = 0;
  bit chk_en = 1'b0;

  // model state
  logic [7:0] m_reg [5];
  int         m_wr, m_err, m_left;
  bit         m_cfg, m_busy;
  bit         p_rw;
  int         p_addr;
  logic [7:0] p_data;

  spi_reg_bank #(.MAX_ADDR(4), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .txn_valid(txn_valid), .txn_rw(txn_rw),
    .txn_addr(txn_addr), .txn_data(txn_data),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .cfg_update(cfg_update),
    .wr_count(wr_count), .err_count(err_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a frame occupies the block for two further edges and
  // commits on the second; anything arriving meanwhile is an overrun.
  task automatic model_step();
    int pre, inc;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      m_wr = 0; m_err = 0; m_left = 0; m_cfg = 1'b0;
    end else begin
      pre = m_left; inc = 0; m_cfg = 1'b0;
      if (pre > 0) begin
        if (pre == 1) begin
          if (p_rw && p_addr <= 4) begin
            m_reg[p_addr] = p_data;
            m_cfg = 1'b1;
            m_wr = (m_wr + 1) % 256;
          end else begin
            inc++;
          end
        end
        m_left = pre - 1;
      end
      if (txn_valid) begin
        if (pre > 0) begin
          inc++;
        end else begin
          p_rw = txn_rw; p_addr = int'(txn_addr); p_data = txn_data;
          m_left = 2;
        end
      end
      m_err = (m_err + inc > 15) ? 15 : m_err + inc;
    end
    m_busy = (m_left > 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cfg_update === 1'b1) cfg_pulses++;
      if (chk_en) begin
        check("cyc_out_7_0",  {24'd0, en_reg_out_7_0},  {24'd0, m_reg[0]});
        check("cyc_out_15_8", {24'd0, en_reg_out_15_8}, {24'd0, m_reg[1]});
        check("cyc_pwm_7_0",  {24'd0, en_reg_pwm_7_0},  {24'd0, m_reg[2]});
        check("cyc_pwm_15_8", {24'd0, en_reg_pwm_15_8}, {24'd0, m_reg[3]});
        check("cyc_duty",     {24'd0, pwm_duty_cycle},  {24'd0, m_reg[4]});
        check("cyc_cfg",      {31'd0, cfg_update},      {31'd0, m_cfg});
        check("cyc_wr",       {24'd0, wr_count},        32'(m_wr));
        check("cyc_err",      {28'd0, err_count},       32'(m_err));
        check("cyc_busy",     {31'd0, busy},            {31'd0, m_busy});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the frame is sampled on the next posedge.
  task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    txn_valid = 1'b1; txn_rw = rw; txn_addr = addr; txn_data = data;
    @(negedge clk);
    txn_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; txn_valid = 1'b1; txn_rw = 1'b1; txn_addr = 7'd4; txn_data = 8'hEE;
    idle(2);
    chk_en = 1'b1;
    txn_valid = 1'b0;
    rst_n = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_duty", {24'd0, pwm_duty_cycle}, 32'd0);
    check("reset_wr", {24'd0, wr_count}, 32'd0);

    // single write, latency 2 edges after capture
    p0 = cfg_pulses;
    send(1'b1, 7'h04, 8'h80);
    check("t1_busy_n", {31'd0, busy}, 32'd1);
    check("t1_duty_n", {24'd0, pwm_duty_cycle}, 32'd0);
    idle(1);
    check("t1_duty_n1", {24'd0, pwm_duty_cycle}, 32'd0);
    idle(1);
    check("t1_duty_n2", {24'd0, pwm_duty_cycle}, 32'h80);
    check("t1_cfg_n2", {31'd0, cfg_update}, 32'd1);
    check("t1_busy_n2", {31'd0, busy}, 32'd0);
    check("t1_wr", {24'd0, wr_count}, 32'd1);
    check("t1_err", {28'd0, err_count}, 32'd0);
    check("t1_out_7_0", {24'd0, en_reg_out_7_0}, 32'd0);
    idle(1);
    check("t1_cfg_gone", {31'd0, cfg_update}, 32'd0);
    check("t1_pulses", 32'(cfg_pulses - p0), 32'd1);

    // all five addresses
    do_reset();
    p0 = cfg_pulses;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 7'(i), 8'hA1 + 8'(i));
      idle(2);
    end
    idle(1);
    check("t2_out_7_0",  {24'd0, en_reg_out_7_0},  32'hA1);
    check("t2_out_15_8", {24'd0, en_reg_out_15_8}, 32'hA2);
    check("t2_pwm_7_0",  {24'd0, en_reg_pwm_7_0},  32'hA3);
    check("t2_pwm_15_8", {24'd0, en_reg_pwm_15_8}, 32'hA4);
    check("t2_duty",     {24'd0, pwm_duty_cycle},  32'hA5);
    check("t2_wr", {24'd0, wr_count}, 32'd5);
    check("t2_pulses", 32'(cfg_pulses - p0), 32'd5);

    // read and out-of-range write are rejected
    do_reset();
    p0 = cfg_pulses;
    send(1'b0, 7'h02, 8'h33);
    idle(2);
    send(1'b1, 7'h05, 8'hFF);
    idle(3);
    check("t3_err", {28'd0, err_count}, 32'd2);
    check("t3_wr", {24'd0, wr_count}, 32'd0);
    check("t3_pwm_7_0", {24'd0, en_reg_pwm_7_0}, 32'd0);
    check("t3_pulses", 32'(cfg_pulses - p0), 32'd0);

    // overrun one cycle after capture
    do_reset();
    send(1'b1, 7'h00, 8'h11);
    send(1'b1, 7'h01, 8'h22);
    idle(3);
    check("t4_out_7_0",  {24'd0, en_reg_out_7_0},  32'h11);
    check("t4_out_15_8", {24'd0, en_reg_out_15_8}, 32'h00);
    check("t4_err", {28'd0, err_count}, 32'd1);
    check("t4_wr", {24'd0, wr_count}, 32'd1);

    // saturation and wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 7'h40 + 7'(i), 8'hFF);
      idle(2);
    end
    idle(1);
    check("t5_err_sat", {28'd0, err_count}, 32'd15);
    for (int i = 0; i < 256; i++) begin
      send(1'b1, 7'(i % 5), 8'(i));
      idle(2);
    end
    idle(1);
    check("t5_wr_wrap", {24'd0, wr_count}, 32'd0);
    check("t5_err_hold", {28'd0, err_count}, 32'd15);
    check("t5_duty", {24'd0, pwm_duty_cycle}, 32'd254);

    // reset mid-transaction
    do_reset();
    send(1'b1, 7'h03, 8'h5A);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t6_pwm_15_8", {24'd0, en_reg_pwm_15_8}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_wr", {24'd0, wr_count}, 32'd0);
    check("t6_err", {28'd0, err_count}, 32'd0);
    idle(3);
    check("t6_no_late_commit", {24'd0, en_reg_pwm_15_8}, 32'd0);
    send(1'b1, 7'h03, 8'h5A);
    idle(3);
    check("t6_fresh_write", {24'd0, en_reg_pwm_15_8}, 32'h5A);
    check("t6_fresh_wr", {24'd0, wr_count}, 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Transaction consumer sitting directly downstream of the SPI deserializer in the clk domain. It accepts one decoded SPI frame per `txn_valid` pulse (read/write flag, 7-bit address, 8-bit data) and commits writes into a bank of five 8-bit configuration registers that drive the output-enable and PWM logic. It also counts accepted writes and rejected transactions (reads, out-of-range addresses, overruns) for debug readback.

## Interface
- `MAX_ADDR`, default 4: highest valid register address; addresses 0..MAX_ADDR are writable.
- `ERR_W`, default 4: width of the saturating error counter.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `txn_valid`  in  1  one-cycle pulse; the `txn_*` fields are valid in the same cycle.
- `txn_rw`  in  1  1 = write, 0 = read.
- `txn_addr`  in  7  register address.
- `txn_data`  in  8  write data.
- `en_reg_out_7_0`  out  8  register at address 0x00.
- `en_reg_out_15_8`  out  8  register at address 0x01.
- `en_reg_pwm_7_0`  out  8  register at address 0x02.
- `en_reg_pwm_15_8`  out  8  register at address 0x03.
- `pwm_duty_cycle`  out  8  register at address 0x04.
- `cfg_update`  out  1  one-cycle pulse in the cycle a register value changes.
- `wr_count`  out  8  count of committed writes; wraps 255 -> 0.
- `err_count`  out  ERR_W  count of rejected transactions; saturates at 2^ERR_W-1.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE -> DECODE when `txn_valid`=1; `txn_rw`/`txn_addr`/`txn_data` are captured into holding registers on that edge.
  - DECODE -> COMMIT unconditionally. Classifies the held transaction as:
    - HIT: write and addr <= MAX_ADDR;
    - RD: read;
    - BAD: write and addr > MAX_ADDR.
    - The classification is registered.
  - COMMIT -> IDLE unconditionally.
    - HIT: the addressed register takes the held data, `cfg_update`=1 for the following cycle, and `wr_count` increments.
    - RD or BAD: no register changes, `err_count` increments.
- Overrun: `txn_valid`=1 while the state is DECODE or COMMIT.
  - The new transaction is dropped and `err_count` increments.
  - The held transaction is unaffected.
- A write of the same value as the current register content still counts as HIT: it pulses `cfg_update` and increments `wr_count`.
- Error counter arithmetic:
  - Per edge, increment = (COMMIT with RD/BAD) + (overrun), so 0..2.
  - The result is a saturating add: never wraps, and holds at all-ones.
- `wr_count` is a plain modulo-256 counter.
- Each address maps to exactly one register. The holding registers are never visible at the outputs.
- Reset (`rst_n`=0 at an edge), in any state, including mid-transaction:
  - state -> IDLE;
  - the held transaction is discarded;
  - all five registers, `wr_count`, `err_count`, `cfg_update` and `busy` -> 0.
  - A `txn_valid` in the same cycle as reset is ignored.

## Timing
- Let `txn_valid` be sampled high at edge N in IDLE.
- Edge N: capture; `busy`=1 from edge N.
- Edge N+1: classification registered.
- Edge N+2 (COMMIT -> IDLE):
  - the register output takes the new value;
  - `cfg_update`=1 for the cycle following edge N+2;
  - `wr_count`/`err_count` update;
  - `busy`=0.
- Write latency from `txn_valid` to the output change is 2 edges after capture.
- `txn_valid` sampled at edges N+1 or N+2 is an overrun. `txn_valid` at edge N+3 is accepted normally.
- Back-to-back transactions: the minimum spacing is 3 clk cycles. The upstream deserializer delivers at most one frame per 16 SCLK periods, so overrun occurs only under a fault.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then write addr 0x04 data 0x80 -> `pwm_duty_cycle`=0x80 exactly 2 edges after capture; `cfg_update` high 1 cycle; `wr_count`=1; `err_count`=0; other registers remain 0x00.
- Write each address 0x00..0x04 with 0xA1..0xA5, spaced 3 cycles -> each register holds its value; `wr_count`=5; `cfg_update` has pulsed 5 times.
- Read addr 0x02, then write addr 0x05 data 0xFF -> no register changes; `err_count`=2; `cfg_update` never asserts.
- Write addr 0x00 data 0x11 with a second `txn_valid` one cycle later (addr 0x01 data 0x22) -> `en_reg_out_7_0`=0x11; `en_reg_out_15_8`=0x00; `err_count`=1; `wr_count`=1.
- 20 bad-address writes -> `err_count` saturates at 15. Then 256 valid writes -> `wr_count` wraps to 0.
- Assert `rst_n`=0 at edge N+1 of a write to 0x03 -> `en_reg_pwm_15_8` stays 0x00; `busy`=0; all counters are 0; a fresh write afterwards completes normally.
